// File: rtl/apb_led_blink_slave.sv
// apb_led_blink_slave
//   APB3 completer on the MSS FIC_2 APB port that blinks one fabric LED.
//   Firmware sets the half-period, polarity and burst length; the block runs
//   either continuously or for COUNT toggles, then reports burst-done.
//
// Optional feature (compile-time macro LED_BLINK_IRQ_EN):
//   defined   - IRQ_EN register at 0x10, IRQ = registered DONE & IRQ_EN
//   undefined - 0x10 is unmapped (PSLVERR), IRQ tied low
//
// Parameters:
//   CNT_W        width of PERIOD and the half-period counter (8..32)
//   WAIT_STATES  APB wait states per access (0..3)
//
// Ports:
//   PCLK, PRESET_N    APB clock / asynchronous active-low reset
//   PSEL, PENABLE,    APB request (setup: PSEL=1 PENABLE=0, access: both 1)
//   PWRITE, PADDR,    PADDR[4:2] selects the register, other bits ignored
//   PWDATA
//   PRDATA, PREADY,   APB response; PRDATA/PSLVERR valid while PREADY=1
//   PSLVERR
//   LED_OUT           registered LED drive (led_state ^ POL)
//   IRQ               burst-done interrupt, level high
//
// Register map:
//   0x00 CTRL   [0] EN  [1] POL  [2] MODE (0 continuous, 1 burst)
//   0x04 PERIOD [CNT_W-1:0] half-period in PCLK cycles (0 behaves as 1)
//   0x08 COUNT  [15:0] toggles per burst
//   0x0C STATUS [0] BUSY  [1] led_state  [2] DONE (w1c)  [31:16] remaining
//   0x10 IRQ_EN [0] (macro builds only)

module apb_led_blink_slave #(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        PCLK,
  input  logic        PRESET_N,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        LED_OUT,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP
  } state_e;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // APB handshake
  logic [1:0] wait_q, wait_d;
  logic       ready_q, ready_d;

  // Registers
  logic             en_q, en_d;
  logic             pol_q, pol_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [15:0]      count_q, count_d;
  logic             done_q, done_d;

  // Blink engine
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_state_q, led_state_d;
  logic [15:0]      rem_q, rem_d;
  logic             burst_q, burst_d;
  logic             led_q, led_d;

  logic [2:0]       idx;
  logic             hit, err, xfer_done, wr;
  logic             wr_ctrl, wr_period, wr_count, wr_status;
  logic [CNT_W-1:0] period_eff;
  logic             tc;
  logic [31:0]      rdata;
  logic             unused_bits;

`ifdef LED_BLINK_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q;
  logic wr_irq_en;
`endif

  assign unused_bits = ^{PADDR[7:5], PADDR[1:0], PWDATA[31:16]};

  // PREADY is registered, so it is raised one cycle early: at the end of the
  // setup phase when there are no wait states, otherwise at the end of the
  // last wait cycle. Dropping PSEL at any point returns the counter to zero.
  always_comb begin
    wait_d  = '0;
    ready_d = 1'b0;
    if (PSEL && !PENABLE) begin
      ready_d = (WAIT_STATES == 0);
    end else if (PSEL && PENABLE && !ready_q) begin
      wait_d  = wait_q + 2'd1;
      ready_d = (32'(wait_q) + 32'd1 == WAIT_STATES);
    end
  end

  assign idx = PADDR[4:2];

  always_comb begin
    hit = 1'b0;
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: hit = 1'b1;
`ifdef LED_BLINK_IRQ_EN
      3'd4:                   hit = 1'b1;
`endif
      default:                hit = 1'b0;
    endcase
  end

  assign err       = !hit || (PWRITE && (idx == 3'd3) && !PWDATA[2]);
  assign xfer_done = PSEL && PENABLE && ready_q;
  assign wr        = xfer_done && PWRITE && !err;
  assign wr_ctrl   = wr && (idx == 3'd0);
  assign wr_period = wr && (idx == 3'd1);
  assign wr_count  = wr && (idx == 3'd2);
  assign wr_status = wr && (idx == 3'd3);
`ifdef LED_BLINK_IRQ_EN
  assign wr_irq_en = wr && (idx == 3'd4);
`endif

  always_comb begin
    rdata = '0;
    case (idx)
      3'd0: rdata = {29'd0, mode_q, pol_q, en_q};
      3'd1: rdata = 32'(period_q);
      3'd2: rdata = {16'd0, count_q};
      3'd3: rdata = {rem_q, 13'd0, done_q, led_state_q, (state_q != S_IDLE)};
`ifdef LED_BLINK_IRQ_EN
      3'd4: rdata = {31'd0, irq_en_q};
`endif
      default: rdata = '0;
    endcase
  end

  assign PREADY  = ready_q;
  assign PSLVERR = xfer_done && err;
  assign PRDATA  = (xfer_done && !PWRITE) ? rdata : '0;
  assign LED_OUT = led_q;
`ifdef LED_BLINK_IRQ_EN
  assign IRQ     = irq_q;
`else
  assign IRQ     = 1'b0;
`endif

  // ">=" rather than "==" so a PERIOD shrink below the running count
  // toggles on the next cycle instead of wrapping the counter.
  assign period_eff = (period_q == '0) ? ONE : period_q;
  assign tc         = (cnt_q >= period_eff - ONE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    led_state_d = led_state_q;
    rem_d       = rem_q;
    burst_d     = burst_q;
    en_d        = en_q;
    pol_d       = pol_q;
    mode_d      = mode_q;
    period_d    = period_q;
    count_d     = count_q;
    done_d      = done_q;
    led_d       = led_state_q ^ pol_q;
`ifdef LED_BLINK_IRQ_EN
    irq_en_d    = irq_en_q;
    if (wr_irq_en) irq_en_d = PWDATA[0];
`endif

    if (wr_ctrl) begin
      en_d   = PWDATA[0];
      pol_d  = PWDATA[1];
      mode_d = PWDATA[2];
    end
    if (wr_period) period_d = PWDATA[CNT_W-1:0];
    if (wr_count)  count_d  = PWDATA[15:0];
    if (wr_status) done_d   = 1'b0;

    // Hardware updates come after register writes so that in the STOP cycle
    // the EN clear and the DONE set override a same-cycle write.
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (wr_ctrl && PWDATA[0] && !en_q) begin
          led_state_d = 1'b0;
          rem_d       = count_q;
          burst_d     = PWDATA[2];
          state_d     = (PWDATA[2] && (count_q == 16'd0)) ? S_STOP : S_RUN;
        end
      end
      S_RUN: begin
        if (wr_ctrl && !PWDATA[0]) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          led_state_d = 1'b0;
        end else if (tc) begin
          cnt_d       = '0;
          led_state_d = !led_state_q;
          if (burst_q) begin
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_STOP: begin
        en_d    = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      wait_q      <= '0;
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      pol_q       <= 1'b0;
      mode_q      <= 1'b0;
      period_q    <= ONE;
      count_q     <= '0;
      done_q      <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      led_state_q <= 1'b0;
      rem_q       <= '0;
      burst_q     <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      ready_q     <= ready_d;
      en_q        <= en_d;
      pol_q       <= pol_d;
      mode_q      <= mode_d;
      period_q    <= period_d;
      count_q     <= count_d;
      done_q      <= done_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      led_state_q <= led_state_d;
      rem_q       <= rem_d;
      burst_q     <= burst_d;
      led_q       <= led_d;
    end
  end

`ifdef LED_BLINK_IRQ_EN
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= done_q && irq_en_q;
    end
  end
`endif

endmodule
